// File: rtl/mod_inv64_if.sv
// Operand/result bus of the modular-inverse unit, including its port to the external
// modular multiplier. The slave side is the inverse unit, the master side is its environment.
interface mod_inv64_if #(
   parameter int P_WIDTH = 64
);
   logic               start_in;
   logic [P_WIDTH-1:0] a_in;
   logic               busy_out;
   logic               done_out;
   logic [P_WIDTH-1:0] inv_out;
   logic               zero_err_out;
   logic [P_WIDTH-1:0] mul_a_out;
   logic [P_WIDTH-1:0] mul_b_out;
   logic [P_WIDTH-1:0] mul_s_in;

   modport slave (
      input  start_in, a_in, mul_s_in,
      output busy_out, done_out, inv_out, zero_err_out, mul_a_out, mul_b_out
   );

   modport master (
      output start_in, a_in, mul_s_in,
      input  busy_out, done_out, inv_out, zero_err_out, mul_a_out, mul_b_out
   );
endinterface

// File: rtl/mod_inv64.sv
// Modular inverse mod p = 2^64-2^32+1 as a^(p-2), by square-and-multiply on an external multiplier.
// Optional MODINV_FASTPATH_EN: reduced operands 0 and 1 return immediately without exponentiation.
module mod_inv64 #(
   parameter int P_WIDTH = 64,
   parameter int MUL_LAT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   mod_inv64_if.slave bus
);
   localparam logic [P_WIDTH-1:0] P_MOD    = P_WIDTH'(64'hFFFF_FFFF_0000_0001);
   localparam logic [63:0]        EXP      = 64'hFFFF_FFFE_FFFF_FFFF;
   localparam int                 CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CW-1:0]      CNT_LAST = CW'(MUL_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQR,
      S_MUL,
      S_WAIT,
      S_DONE
   } state_t;

   typedef enum logic {
      RET_MUL,
      RET_NEXT
   } ret_t;

   state_t             r_state, w_state_nxt;
   ret_t               r_ret, w_ret_nxt;
   logic [5:0]         r_i, w_i_nxt;
   logic [CW-1:0]      r_cnt, w_cnt_nxt;
   logic [P_WIDTH-1:0] r_a, w_a_nxt;
   logic [P_WIDTH-1:0] r_r, w_r_nxt;
   logic [P_WIDTH-1:0] r_mul_a, w_mul_a_nxt;
   logic [P_WIDTH-1:0] r_mul_b, w_mul_b_nxt;
   logic [P_WIDTH-1:0] r_inv, w_inv_nxt;
   logic               r_zero, w_zero_nxt;
   logic [P_WIDTH-1:0] w_a_red;
   logic               w_fast;

   // Single conditional subtract suffices: any 64-bit value is below 2p.
   assign w_a_red = (bus.a_in >= P_MOD) ? (bus.a_in - P_MOD) : bus.a_in;

`ifdef MODINV_FASTPATH_EN
   assign w_fast = (r_a[P_WIDTH-1:1] == '0);
`else
   assign w_fast = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ret_nxt   = r_ret;
      w_i_nxt     = r_i;
      w_cnt_nxt   = r_cnt;
      w_a_nxt     = r_a;
      w_r_nxt     = r_r;
      w_mul_a_nxt = r_mul_a;
      w_mul_b_nxt = r_mul_b;
      w_inv_nxt   = r_inv;
      w_zero_nxt  = r_zero;
      case (r_state)
         S_IDLE: begin
            if (bus.start_in) begin
               w_a_nxt     = w_a_red;
               w_r_nxt     = w_a_red;
               w_i_nxt     = 6'd62;
               w_state_nxt = S_SQR;
            end
         end
         S_SQR: begin
            if (w_fast) begin
               w_inv_nxt   = r_a;
               w_zero_nxt  = (r_a == '0);
               w_state_nxt = S_DONE;
            end else begin
               w_mul_a_nxt = r_r;
               w_mul_b_nxt = r_r;
               w_cnt_nxt   = '0;
               w_ret_nxt   = RET_MUL;
               w_state_nxt = S_WAIT;
            end
         end
         S_MUL: begin
            w_mul_a_nxt = r_r;
            w_mul_b_nxt = r_a;
            w_cnt_nxt   = '0;
            w_ret_nxt   = RET_NEXT;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == CNT_LAST) begin
               w_r_nxt = bus.mul_s_in;
               // Bit-skip and index-advance resolve in the capture cycle so only issue/wait cycles cost time.
               if ((r_ret == RET_MUL) && EXP[r_i]) begin
                  w_state_nxt = S_MUL;
               end else if (r_i == 6'd0) begin
                  w_inv_nxt   = bus.mul_s_in;
                  w_zero_nxt  = (r_a == '0);
                  w_state_nxt = S_DONE;
               end else begin
                  w_i_nxt     = r_i - 6'd1;
                  w_state_nxt = S_SQR;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state <= S_IDLE;
         r_ret   <= RET_MUL;
         r_i     <= '0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_r     <= '0;
         r_mul_a <= '0;
         r_mul_b <= '0;
         r_inv   <= '0;
         r_zero  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ret   <= w_ret_nxt;
         r_i     <= w_i_nxt;
         r_cnt   <= w_cnt_nxt;
         r_a     <= w_a_nxt;
         r_r     <= w_r_nxt;
         r_mul_a <= w_mul_a_nxt;
         r_mul_b <= w_mul_b_nxt;
         r_inv   <= w_inv_nxt;
         r_zero  <= w_zero_nxt;
      end
   end

   assign bus.busy_out     = (r_state == S_SQR) || (r_state == S_MUL) || (r_state == S_WAIT);
   assign bus.done_out     = (r_state == S_DONE);
   assign bus.inv_out      = r_inv;
   assign bus.zero_err_out = r_zero;
   assign bus.mul_a_out    = r_mul_a;
   assign bus.mul_b_out    = r_mul_b;
endmodule

// File: tb/tb_mod_inv64.sv
// Bench for mod_inv64: behavioural 3-cycle modular multiplier, directed vector table,
// plus hand-written sequences for ignored starts and mid-operation reset.
module tb_mod_inv64;
   localparam int          MUL_LAT   = 3;
   localparam int          FULL_DONE = 125 * (MUL_LAT + 1) + 1;
   localparam logic [63:0] P         = 64'hFFFF_FFFF_0000_0001;
`ifdef MODINV_FASTPATH_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   mod_inv64_if #(.P_WIDTH(64)) bif ();

   mod_inv64 #(.P_WIDTH(64), .MUL_LAT(MUL_LAT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y);
      logic [127:0] pr;
      pr = {64'd0, x} * {64'd0, y};
      return 64'(pr % {64'd0, P});
   endfunction

   // Operands registered at edge n are sampled by the DUT at edge n+MUL_LAT: two register stages.
   logic [63:0] m_s1, m_s2;
   always @(posedge clk) begin
      m_s1 <= mulmod(bif.mul_a_out, bif.mul_b_out);
      m_s2 <= m_s1;
   end
   assign bif.mul_s_in = m_s2;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
      end
   endtask

   function automatic int done_at(input bit triv);
      return (FAST && triv) ? 2 : FULL_DONE;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " busy"}, {63'd0, bif.busy_out}, 64'd0);
      chk({nm, " done"}, {63'd0, bif.done_out}, 64'd0);
      chk({nm, " inv"}, bif.inv_out, 64'd0);
      chk({nm, " zero_err"}, {63'd0, bif.zero_err_out}, 64'd0);
      chk({nm, " mul_a"}, bif.mul_a_out, 64'd0);
      chk({nm, " mul_b"}, bif.mul_b_out, 64'd0);
   endtask

   // Called just after an edge with the DUT idle; start is accepted at the next edge (cycle 0).
   task automatic run_op(input logic [63:0] a, input logic [63:0] ei, input logic ez,
                         input bit triv, input string nm);
      logic [63:0] inv_prev, ma_prev;
      int          edone, dc, extra;
      bit          busy_ok, hold_ok;
      edone    = done_at(triv);
      inv_prev = bif.inv_out;
      ma_prev  = bif.mul_a_out;
      dc = -1; extra = 0; busy_ok = 1'b1; hold_ok = 1'b1;
      bif.start_in = 1'b1;
      bif.a_in     = a;
      tick();
      bif.start_in = 1'b0;
      for (int c = 1; c <= edone + 3; c++) begin
         if (bif.busy_out !== (c < edone)) busy_ok = 1'b0;
         if (bif.done_out === 1'b1) begin
            if (dc < 0) dc = c;
            else extra++;
         end
         if (dc < 0 && bif.inv_out !== inv_prev) hold_ok = 1'b0;
         tick();
      end
      chk({nm, " done_cycle"}, 64'(dc), 64'(edone));
      chk({nm, " done_extra"}, 64'(extra), 64'd0);
      chk({nm, " busy_window"}, {63'd0, busy_ok}, 64'd1);
      chk({nm, " inv_hold"}, {63'd0, hold_ok}, 64'd1);
      chk({nm, " inv"}, bif.inv_out, ei);
      chk({nm, " zero_err"}, {63'd0, bif.zero_err_out}, {63'd0, ez});
      if (ez == 1'b0) chk({nm, " inv_times_a"}, mulmod(bif.inv_out, a % P), 64'd1);
`ifdef MODINV_FASTPATH_EN
      if (triv) chk({nm, " mul_a_kept"}, bif.mul_a_out, ma_prev);
`endif
   endtask

   typedef struct {
      logic [63:0] a;
      logic [63:0] inv;
      logic        zero;
      bit          triv;
      string       nm;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      int   e1, ndone_bad;
      bit   seen1, seen2;
      logic [63:0] inv1, inv2;

      vecs[0] = '{64'd2,                   64'h7FFF_FFFF_8000_0001, 1'b0, 1'b0, "a2"};
      vecs[1] = '{64'd0,                   64'd0,                   1'b1, 1'b1, "a0"};
      vecs[2] = '{64'd1,                   64'd1,                   1'b0, 1'b1, "a1"};
      vecs[3] = '{64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, "pm1"};
      vecs[4] = '{64'h4000,                64'hFFFB_FFFF_0004_0001, 1'b0, 1'b0, "n16k"};
      vecs[5] = '{64'hFFFF_FFFF_0000_0001, 64'd0,                   1'b1, 1'b1, "ap"};
      vecs[6] = '{64'd3,                   64'hAAAA_AAAA_0000_0001, 1'b0, 1'b0, "a3"};
      vecs[7] = '{64'hFFFF_FFFF_0000_0002, 64'd1,                   1'b0, 1'b1, "ap1"};
      vecs[8] = '{64'hFFFF_FFFF_0000_0003, 64'h7FFF_FFFF_8000_0001, 1'b0, 1'b0, "ap2"};

      rst_n        = 1'b1;
      bif.start_in = 1'b0;
      bif.a_in     = 64'd0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      chk_all_zero("reset");

      foreach (vecs[k]) run_op(vecs[k].a, vecs[k].inv, vecs[k].zero, vecs[k].triv, vecs[k].nm);

      // Stray starts at cycle 10 (busy) and 501 (done) are ignored; the one at 502 is taken.
      e1 = done_at(1'b1);
      ndone_bad = 0; seen1 = 1'b0; seen2 = 1'b0; inv1 = '0; inv2 = '0;
      bif.start_in = 1'b1;
      bif.a_in     = 64'd2;
      tick();
      bif.start_in = 1'b0;
      for (int c = 1; c <= 505 + e1; c++) begin
         if (bif.done_out === 1'b1) begin
            if (c == FULL_DONE) begin seen1 = 1'b1; inv1 = bif.inv_out; end
            else if (c == FULL_DONE + 1 + e1) begin seen2 = 1'b1; inv2 = bif.inv_out; end
            else ndone_bad++;
         end
         if (c == 10)                 begin bif.start_in = 1'b1; bif.a_in = 64'd5; end
         else if (c == FULL_DONE)     begin bif.start_in = 1'b1; bif.a_in = 64'd3; end
         else if (c == FULL_DONE + 1) begin bif.start_in = 1'b1; bif.a_in = 64'd1; end
         else                         bif.start_in = 1'b0;
         tick();
      end
      chk("ign done_first", {63'd0, seen1}, 64'd1);
      chk("ign inv_first", inv1, 64'h7FFF_FFFF_8000_0001);
      chk("ign done_restart", {63'd0, seen2}, 64'd1);
      chk("ign inv_restart", inv2, 64'd1);
      chk("ign stray_done", 64'(ndone_bad), 64'd0);

      // Reset asserted at cycle 200 of an operation aborts it and clears every output.
      run_op(64'd2, 64'h7FFF_FFFF_8000_0001, 1'b0, 1'b0, "pre_rst");
      bif.start_in = 1'b1;
      bif.a_in     = 64'd3;
      tick();
      bif.start_in = 1'b0;
      for (int c = 1; c < 200; c++) tick();
      chk("rst busy_before", {63'd0, bif.busy_out}, 64'd1);
      rst_n = 1'b1;
      tick();
      chk_all_zero("midrst");
      rst_n = 1'b0;
      tick();
      run_op(64'h4000, 64'hFFFB_FFFF_0004_0001, 1'b0, 1'b0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mod_inv64.md
# mod_inv64

Sequential modular-inverse unit for the NTT datapath prime p = 2^64 − 2^32 + 1. It computes inv = a^(p−2) mod p by fixed-exponent left-to-right square-and-multiply, driving an external pipelined 64-bit modular multiplier through a dedicated operand/result port. It is the inverse-direction companion of the modular multiplier. It produces the per-transform scaling constants (for example N^−1 and inverse twiddle seeds) that the inverse NTT needs, and it is loaded once per configuration rather than per sample.

## Interface
- P_WIDTH, 64, operand width
- MUL_LAT, 3, latency in cycles of the attached modular multiplier, from operands applied to product valid
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset; synchronous and active-high (asserted = 1)
- start_in  in  1  request pulse; sampled only in IDLE
- a_in  in  P_WIDTH  operand, sampled with an accepted start_in
- busy_out  out  1  high from the cycle after acceptance until done_out
- done_out  out  1  one-cycle pulse when inv_out becomes valid
- inv_out  out  P_WIDTH  result; held until the next accepted start
- zero_err_out  out  1  set with done_out when the reduced operand is 0; held with inv_out
- mul_a_out  out  P_WIDTH  multiplier operand A (registered)
- mul_b_out  out  P_WIDTH  multiplier operand B (registered)
- mul_s_in  in  P_WIDTH  multiplier product (A·B mod p), valid MUL_LAT cycles after operands change

## Operation
- Exponent E = p−2 = 0xFFFFFFFE_FFFFFFFF is hard-wired.
  - Bit 63 initialises r = a.
  - Bits 62..0 each cost one squaring (63 total) plus one multiply by a when the bit is 1 (62 total, because bit 32 = 0).
  - Total: 125 multiplier operations.
- States:
  - IDLE: on start_in, reduce the operand (a_reg = a_in ≥ p ? a_in − p : a_in), set r = a_reg and bit index i = 62, then go to SQR.
  - SQR: drive A = B = r, then go to WAIT with ret = MUL.
  - MUL: if E[i] = 1, drive A = r and B = a_reg, then go to WAIT with ret = NEXT. If E[i] = 0, skip directly to NEXT handling.
  - WAIT: count MUL_LAT cycles, then capture r = mul_s_in.
  - NEXT: if i = 0, go to DONE; otherwise decrement i and go to SQR.
  - DONE: inv_out = r, pulse done_out, return to IDLE.
- Phase transitions with no multiplier activity happen in the same cycle as the capture. Only issue cycles and wait cycles consume time.
- Operands stay stable for the entire WAIT. The multiplier is free-running, so no handshake is needed on it.
- Zero operand: the computation runs normally (the result is naturally 0) and zero_err_out = 1.
- Boundary behaviour:
  - start_in while busy is ignored.
  - start_in coincident with done_out is ignored; acceptance needs IDLE on the following cycle.
  - rst_n mid-operation aborts immediately.

## Timing
- Reset values: busy_out = 0, done_out = 0, inv_out = 0, zero_err_out = 0, mul_a_out = 0, mul_b_out = 0, state = IDLE.
- Cycle 0 is the start acceptance. The k-th operation (k = 1..125) issues at cycle 1+(k−1)(MUL_LAT+1) and captures at cycle k(MUL_LAT+1).
- done_out is asserted at cycle 125(MUL_LAT+1)+1: cycle 501 for MUL_LAT = 3.
- busy_out is high on cycles 1 through done−1.
- The next start is accepted no earlier than done+1.
- inv_out and zero_err_out change only on the done_out cycle or on reset.

## Configuration
- MODINV_FASTPATH_EN
  - Defined: a reduced operand of 0 or 1 skips exponentiation. DONE is reached at cycle 2, done_out pulses with inv_out = a_reg, and zero_err_out is set for 0. The multiplier ports stay at their previous values.
  - Undefined: every operand takes the full 125-operation latency.

## Test plan
- a_in = 2, MUL_LAT = 3, with a behavioural multiplier model → inv_out = 0x7FFFFFFF80000001, done_out at cycle 501, busy_out high on cycles 1–500.
- a_in = p−1 = 0xFFFFFFFF00000000 → inv_out = 0xFFFFFFFF00000000. a_in = 0x4000 (N = 16384) → inv_out·0x4000 mod p = 1; check against the model.
- a_in = p (reduces to 0) and a_in = 0 → inv_out = 0, zero_err_out = 1. With MODINV_FASTPATH_EN, done_out at cycle 2; without it, at cycle 501.
- a_in = 1 → inv_out = 1, zero_err_out = 0. Fast-path timing as above.
- start_in pulsed at cycles 10 and 501 during an operation → ignored, single done_out at 501. A new start at 502 is accepted.
- rst_n = 1 at cycle 200 → next cycle busy_out = 0 and all outputs 0. A start two cycles after reset release completes correctly 501 cycles later.
